mac_tx_packet_arbiter: RTL and testbench

MAC_TX_PACKET_ARBITER -- requirements
Module: mac_tx_packet_arbiter

---
 rtl/mac_tx_packet_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mac_tx_packet_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_packet_arbiter.sv
// Round-robin packet arbiter: grants one client channel at a time onto a registered
// MAC transmit bus, holding the grant from SOP through EOP.
module mac_tx_packet_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 64,
    localparam int MOD_WIDTH   = $clog2(DATA_WIDTH / 8),
    localparam int CH_WIDTH    = $clog2(NUM_CHANNELS)
) (
    input  logic                               clkTxRxInterface,
    input  logic                               rstTxRxInterface,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] chanData,
    input  logic [NUM_CHANNELS-1:0]            chanValid,
    input  logic [NUM_CHANNELS-1:0]            chanStartOfPacket,
    input  logic [NUM_CHANNELS-1:0]            chanEndOfPacket,
    input  logic [NUM_CHANNELS*MOD_WIDTH-1:0]  chanPacketLengthModulus,
    output logic [NUM_CHANNELS-1:0]            chanReady,
    output logic [DATA_WIDTH-1:0]              transmitData,
    output logic                               transmitValid,
    output logic                               transmitStartOfPacket,
    output logic                               transmitEndOfPacket,
    output logic [MOD_WIDTH-1:0]               transmitPacketLengthModulus,
    input  logic                               transmitFIFOFull,
    output logic [CH_WIDTH-1:0]                grantChannel,
    output logic [15:0]                        packetCount,
    output logic [15:0]                        dropCount,
    output logic [15:0]                        protocolErrorCount
);

    typedef enum logic {IDLE = 1'b0, FORWARD = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [CH_WIDTH-1:0]   grant_q, grant_d;
    logic [CH_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic                  first_beat_q, first_beat_d;

    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_valid_q, tx_sop_q, tx_eop_q;
    logic [MOD_WIDTH-1:0]  tx_mod_q;
    logic [15:0]           pkt_cnt_q, drop_cnt_q, perr_cnt_q;

    logic [DATA_WIDTH-1:0] data_arr [NUM_CHANNELS];
    logic [MOD_WIDTH-1:0]  mod_arr  [NUM_CHANNELS];
    logic [CH_WIDTH-1:0]   cand     [NUM_CHANNELS];

    logic                  req_found;
    logic [CH_WIDTH-1:0]   req_idx;
    logic                  transfer, beat_sop, beat_eop, drop_any, perr;

    // cand[k] is the channel examined k+1 positions after the last grant
    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign data_arr[gi] = chanData[gi*DATA_WIDTH +: DATA_WIDTH];
            assign mod_arr[gi]  = chanPacketLengthModulus[gi*MOD_WIDTH +: MOD_WIDTH];
            assign cand[gi]     = CH_WIDTH'((int'(last_grant_q) + gi + 1) % NUM_CHANNELS);
        end
    endgenerate

    always_comb begin
        req_found = 1'b0;
        req_idx   = last_grant_q;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (!req_found && chanValid[cand[k]] && chanStartOfPacket[cand[k]]) begin
                req_found = 1'b1;
                req_idx   = cand[k];
            end
        end
    end

    assign beat_sop = chanStartOfPacket[grant_q];
    assign beat_eop = chanEndOfPacket[grant_q];
    assign transfer = (state_q == FORWARD) && chanValid[grant_q] && !transmitFIFOFull;
    assign drop_any = (state_q == IDLE) && |(chanValid & ~chanStartOfPacket);
    assign perr     = transfer && beat_sop && !first_beat_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_beat_d = first_beat_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d      = FORWARD;
                    grant_d      = req_idx;
                    first_beat_d = 1'b1;
                end
            end
            FORWARD: begin
                if (transfer) begin
                    first_beat_d = 1'b0;
                    if (beat_eop) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Headless beats seen while idle are accepted only to be thrown away
    always_comb begin
        chanReady = '0;
        if (!rstTxRxInterface) begin
            if (state_q == IDLE) begin
                chanReady = chanValid & ~chanStartOfPacket;
            end else begin
                chanReady[grant_q] = !transmitFIFOFull;
            end
        end
    end

    always_ff @(posedge clkTxRxInterface) begin
        if (rstTxRxInterface) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_WIDTH'(NUM_CHANNELS - 1);
            first_beat_q <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_sop_q     <= 1'b0;
            tx_eop_q     <= 1'b0;
            tx_mod_q     <= '0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            perr_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_beat_q <= first_beat_d;
            tx_valid_q   <= transfer;
            tx_sop_q     <= transfer && beat_sop && first_beat_q;
            tx_eop_q     <= transfer && beat_eop;
            tx_mod_q     <= (transfer && beat_eop) ? mod_arr[grant_q] : '0;
            if (transfer) begin
                tx_data_q <= data_arr[grant_q];
            end
            if (transfer && beat_eop) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (drop_any && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (perr && perr_cnt_q != 16'hFFFF) begin
                perr_cnt_q <= perr_cnt_q + 16'd1;
            end
        end
    end

    assign transmitData                = tx_data_q;
    assign transmitValid               = tx_valid_q;
    assign transmitStartOfPacket       = tx_sop_q;
    assign transmitEndOfPacket         = tx_eop_q;
    assign transmitPacketLengthModulus = tx_mod_q;
    assign grantChannel                = grant_q;
    assign packetCount                 = pkt_cnt_q;
    assign dropCount                   = drop_cnt_q;
    assign protocolErrorCount          = perr_cnt_q;

endmodule

// File: tb/tb_mac_tx_packet_arbiter.sv
// Bench for mac_tx_packet_arbiter: idle-arbitration vector table, directed corner
// sequences, and a randomized run checked against a packet-order scoreboard.
module tb_mac_tx_packet_arbiter;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int MW = 3;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N*W-1:0]  chan_data;
    logic [N-1:0]    chan_valid, chan_sop, chan_eop, chan_ready;
    logic [N*MW-1:0] chan_mod;
    logic [W-1:0]    tx_data;
    logic            tx_valid, tx_sop, tx_eop, fifo_full;
    logic [MW-1:0]   tx_mod;
    logic [CW-1:0]   grant;
    logic [15:0]     pkt_cnt, drop_cnt, perr_cnt;

    int compared   = 0;
    int mismatched = 0;

    mac_tx_packet_arbiter #(.NUM_CHANNELS(N), .DATA_WIDTH(W)) dut (
        .clkTxRxInterface           (clk),
        .rstTxRxInterface           (rst),
        .chanData                   (chan_data),
        .chanValid                  (chan_valid),
        .chanStartOfPacket          (chan_sop),
        .chanEndOfPacket            (chan_eop),
        .chanPacketLengthModulus    (chan_mod),
        .chanReady                  (chan_ready),
        .transmitData               (tx_data),
        .transmitValid              (tx_valid),
        .transmitStartOfPacket      (tx_sop),
        .transmitEndOfPacket        (tx_eop),
        .transmitPacketLengthModulus(tx_mod),
        .transmitFIFOFull           (fifo_full),
        .grantChannel               (grant),
        .packetCount                (pkt_cnt),
        .dropCount                  (drop_cnt),
        .protocolErrorCount         (perr_cnt)
    );

    typedef struct packed {
        logic [W-1:0]  data;
        logic          sop;
        logic          eop;
        logic [MW-1:0] mod;
    } beat_t;

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  sop;
        logic [N-1:0]  exp_ready;
        logic [CW-1:0] exp_grant;
        logic [15:0]   exp_drop;
    } vec_t;

    vec_t  vecs [7];
    beat_t pkt_q [N][4][$];
    beat_t ch_q  [N][$];
    beat_t exp_q [$];
    beat_t bt, got;
    logic [N-1:0] fire;
    logic  prev_eop;
    int    len, cyc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan(input int ch, input logic v, input logic s, input logic e,
                            input logic [MW-1:0] m, input logic [W-1:0] d);
        chan_valid[ch]         = v;
        chan_sop[ch]           = s;
        chan_eop[ch]           = e;
        chan_mod[ch*MW +: MW]  = m;
        chan_data[ch*W +: W]   = d;
    endtask

    task automatic clear_inputs();
        chan_valid = '0;
        chan_sop   = '0;
        chan_eop   = '0;
        chan_mod   = '0;
        chan_data  = '0;
        fifo_full  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();

        // Reset state
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_ready", chan_ready, 0);
        check("rst_counters", {pkt_cnt, drop_cnt, perr_cnt}, 0);
        rst = 1'b0;

        // Idle-state arbitration and drop vectors, each from a fresh reset
        vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 16'd0};
        vecs[1] = '{4'b0110, 4'b0110, 4'b0000, 2'd1, 16'd0};
        vecs[2] = '{4'b1000, 4'b0000, 4'b1000, 2'd0, 16'd1};
        vecs[3] = '{4'b1101, 4'b0100, 4'b1001, 2'd2, 16'd1};
        vecs[4] = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 16'd0};
        vecs[5] = '{4'b1111, 4'b1000, 4'b0111, 2'd3, 16'd1};
        vecs[6] = '{4'b1010, 4'b1010, 4'b0000, 2'd1, 16'd0};
        for (int v = 0; v < 7; v++) begin
            do_reset();
            chan_valid = vecs[v].valid;
            chan_sop   = vecs[v].sop;
            @(negedge clk);
            check($sformatf("vec%0d_ready", v), chan_ready, vecs[v].exp_ready);
            tick();
            clear_inputs();
            check($sformatf("vec%0d_grant", v), grant, vecs[v].exp_grant);
            check($sformatf("vec%0d_drop", v), drop_cnt, vecs[v].exp_drop);
            check($sformatf("vec%0d_txv", v), tx_valid, 0);
            $display("vector %0d: valid=%b sop=%b ready=%b grant=%0d drop=%0d",
                     v, vecs[v].valid, vecs[v].sop, chan_ready, grant, drop_cnt);
        end

        // Single-beat packet on channel 2 with modulus 3
        do_reset();
        set_chan(2, 1, 1, 1, 3'd3, 64'hC0FFEE_0000_0002);
        tick();
        @(negedge clk);
        check("single_ready", chan_ready, 4'b0100);
        tick();
        set_chan(2, 0, 0, 0, 0, 0);
        set_chan(0, 1, 0, 0, 0, 0);
        check("single_beat", {tx_valid, tx_sop, tx_eop, tx_mod}, {1'b1, 1'b1, 1'b1, 3'd3});
        check("single_data", tx_data, 64'hC0FFEE_0000_0002);
        check("single_grant", grant, 2);
        @(negedge clk);
        check("single_back_idle", chan_ready, 4'b0001);
        set_chan(0, 0, 0, 0, 0, 0);
        tick();
        check("single_no_more", {tx_valid, tx_sop, tx_eop, tx_mod}, 0);
        check("single_data_hold", tx_data, 64'hC0FFEE_0000_0002);
        $display("single-beat: pkt_cnt=%0d", pkt_cnt);
        check("single_pkt_cnt", pkt_cnt, 1);

        // Backpressure for 5 cycles mid-packet on channel 1
        do_reset();
        set_chan(1, 1, 1, 0, 3'd7, 64'h1111_0000);
        tick();
        tick();
        set_chan(1, 1, 0, 0, 3'd7, 64'h1111_0001);
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check($sformatf("stall%0d_ready", s), chan_ready, 0);
            tick();
            check($sformatf("stall%0d_txv", s), tx_valid, 0);
            check($sformatf("stall%0d_grant", s), grant, 1);
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check("stall_resume_ready", chan_ready, 4'b0010);
        tick();
        check("stall_beat1", {tx_valid, tx_sop, tx_eop, tx_mod, tx_data}, {1'b1, 1'b0, 1'b0, 3'd0, 64'h1111_0001});
        set_chan(1, 1, 0, 1, 3'd5, 64'h1111_0002);
        tick();
        set_chan(1, 0, 0, 0, 0, 0);
        check("stall_beat2", {tx_valid, tx_sop, tx_eop, tx_mod, tx_data}, {1'b1, 1'b0, 1'b1, 3'd5, 64'h1111_0002});
        check("stall_pkt_cnt", pkt_cnt, 1);
        $display("stall: resumed with grant=%0d pkt_cnt=%0d", grant, pkt_cnt);

        // Unexpected SOP on the second beat of a channel-0 packet
        do_reset();
        set_chan(0, 1, 1, 0, 0, 64'hAA00);
        tick();
        tick();
        check("perr_first_sop", {tx_valid, tx_sop}, 2'b11);
        set_chan(0, 1, 1, 0, 0, 64'hAA01);
        tick();
        check("perr_forwarded", {tx_valid, tx_sop, tx_data}, {1'b1, 1'b0, 64'hAA01});
        check("perr_count", perr_cnt, 1);
        set_chan(0, 1, 0, 1, 3'd1, 64'hAA02);
        tick();
        set_chan(0, 0, 0, 0, 0, 0);
        check("perr_eop", {tx_valid, tx_eop, tx_mod}, {1'b1, 1'b1, 3'd1});
        check("perr_pkt_cnt", pkt_cnt, 1);
        $display("protocol error: perr_cnt=%0d", perr_cnt);

        // Reset mid-packet, then restart from channel 0
        do_reset();
        set_chan(0, 1, 1, 0, 3'd5, 64'hD0);
        tick();
        tick();
        set_chan(0, 1, 0, 0, 3'd5, 64'hD1);
        tick();
        set_chan(0, 1, 0, 0, 3'd5, 64'hD2);
        rst = 1'b1;
        tick();
        check("midrst_tx", {tx_valid, tx_sop, tx_eop, tx_mod, tx_data}, 0);
        check("midrst_grant_cnt", {grant, pkt_cnt, drop_cnt, perr_cnt}, 0);
        check("midrst_ready", chan_ready, 0);
        rst = 1'b0;
        set_chan(0, 1, 1, 0, 0, 64'hE0);
        set_chan(1, 1, 1, 1, 0, 64'hE1);
        tick();
        check("midrst_regrant", grant, 0);
        @(negedge clk);
        check("midrst_ready_hold", chan_ready, 4'b0001);
        tick();
        check("midrst_new_sop", {tx_valid, tx_sop, tx_data}, {1'b1, 1'b1, 64'hE0});
        set_chan(0, 1, 0, 1, 3'd2, 64'hE2);
        tick();
        clear_inputs();
        check("midrst_new_eop", {tx_valid, tx_eop, tx_mod, tx_data}, {1'b1, 1'b1, 3'd2, 64'hE2});
        check("midrst_pkt_cnt", pkt_cnt, 1);
        $display("mid-packet reset: restarted on channel 0, pkt_cnt=%0d", pkt_cnt);

        // Randomized: every channel queues 4 packets; strict round-robin order expected
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int ch = 0; ch < N; ch++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    bt.data = {$urandom, $urandom};
                    bt.sop  = (b == 0);
                    bt.eop  = (b == len - 1);
                    bt.mod  = MW'($urandom_range(0, 7));
                    ch_q[ch].push_back(bt);
                    if (!bt.eop) bt.mod = '0;
                    pkt_q[ch][p].push_back(bt);
                end
            end
        end
        for (int p = 0; p < 4; p++)
            for (int ch = 0; ch < N; ch++)
                foreach (pkt_q[ch][p][b]) exp_q.push_back(pkt_q[ch][p][b]);

        prev_eop = 1'b0;
        cyc      = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            for (int ch = 0; ch < N; ch++) begin
                if (ch_q[ch].size() > 0)
                    set_chan(ch, 1, ch_q[ch][0].sop, ch_q[ch][0].eop, ch_q[ch][0].mod, ch_q[ch][0].data);
                else
                    set_chan(ch, 0, 0, 0, 0, 0);
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            fire = chan_valid & chan_ready;
            tick();
            cyc++;
            for (int ch = 0; ch < N; ch++)
                if (fire[ch]) void'(ch_q[ch].pop_front());
            if (prev_eop) check("rand_idle_gap", tx_valid, 0);
            if (tx_valid) begin
                got = '{tx_data, tx_sop, tx_eop, tx_mod};
                bt  = exp_q.pop_front();
                check("rand_beat", got, bt);
                $display("rand beat: data=%h sop=%b eop=%b mod=%0d", tx_data, tx_sop, tx_eop, tx_mod);
            end else begin
                check("rand_idle_flags", {tx_sop, tx_eop, tx_mod}, 0);
            end
            prev_eop = tx_valid && tx_eop;
        end
        clear_inputs();
        check("rand_all_delivered", exp_q.size(), 0);
        check("rand_pkt_cnt", pkt_cnt, N * 4);
        check("rand_no_drops", {drop_cnt, perr_cnt}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
